fm6126_config_rx: RTL and testbench

Receiver/decoder for the FM6126 configuration protocol on the HUB75 lines (rgb1, rgb2, latch, pixclock). It samples the bus in the clk_in domain and counts pixclock rising edges while latch is high to classify each latch pulse. Register-write commands (12 or 13 latched clocks) are decoded and their 16-bit values captured. It sits beside the panel driver as an emulated panel front end and as a self-check monitor for the FM6126 init sequence.

---
 rtl/fm6126_config_rx.sv | 149 ++++++++++++++
 tb/tb_fm6126_config_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fm6126_config_rx.sv
// FM6126 configuration receiver: classifies HUB75 latch pulses and captures REG12/REG13 writes.
// Latency: decode outputs register on the clk_in edge that sees latch fall; strobes last one cycle.
// Backpressure: none; the bus is observed passively and every latch pulse is decoded.
module fm6126_config_rx #(
  parameter int PANEL_WIDTH = 64
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [2:0]  rgb1_in,
  input  logic [2:0]  rgb2_in,
  input  logic        latch_in,
  input  logic        pixclock_in,
  output logic [15:0] reg12_q,
  output logic [15:0] reg13_q,
  output logic        reg12_valid,
  output logic        reg13_valid,
  output logic        init_done,
  output logic        write_strobe,
  output logic        write_sel,
  output logic        data_latch_strobe,
  output logic [4:0]  latch_clocks,
  output logic        cmd_err,
  output logic        lane_err,
  output logic        len_err
);

  localparam logic [6:0] PW = 7'(PANEL_WIDTH);

  // Bus samples; armed blocks a pixclock already high at reset release from counting as an edge.
  logic        pix_q;
  logic        lat_q;
  logic        armed;

  // Segment state: shift register, segment length, latched-clock count, lane mismatch flag.
  logic [15:0] shreg;
  logic [6:0]  seg_cnt;
  logic [4:0]  lat_cnt;
  logic        seg_lane_bad;

  // Combinational next values and decode terms.
  logic        pix_edge;
  logic        lat_fall;
  logic        lanes_differ;
  logic [15:0] shreg_nxt;
  logic [6:0]  seg_cnt_nxt;
  logic [4:0]  lat_cnt_nxt;
  logic        lane_bad_nxt;
  logic [5:0]  cnt_f;
  logic [4:0]  cnt_sat;
  logic        is_data;
  logic        is_r12;
  logic        is_r13;
  logic        is_cand;
  logic        bad_len;
  logic        accept;

  // Edge detection and post-edge segment values (the edge in the falling cycle belongs to this segment).
  always_comb begin
    pix_edge     = armed & pixclock_in & ~pix_q;
    lat_fall     = lat_q & ~latch_in;
    lanes_differ = (|{rgb1_in, rgb2_in}) & ~(&{rgb1_in, rgb2_in});

    shreg_nxt    = shreg;
    seg_cnt_nxt  = seg_cnt;
    lat_cnt_nxt  = lat_cnt;
    lane_bad_nxt = seg_lane_bad;
    if (pix_edge) begin
      shreg_nxt = {rgb1_in[0], shreg[15:1]};
      if (lanes_differ) lane_bad_nxt = 1'b1;
      if (seg_cnt != 7'd127) seg_cnt_nxt = seg_cnt + 7'd1;
      if ((latch_in | lat_q) && lat_cnt != 5'd31) lat_cnt_nxt = lat_cnt + 5'd1;
    end

    cnt_f   = {1'b0, lat_cnt} + 6'(pix_edge & lat_q);
    cnt_sat = (cnt_f > 6'd31) ? 5'd31 : cnt_f[4:0];
    is_data = (cnt_f >= 6'd1) && (cnt_f <= 6'd3);
    is_r12  = (cnt_f == 6'd12);
    is_r13  = (cnt_f == 6'd13);
    is_cand = is_r12 | is_r13;
    bad_len = (seg_cnt_nxt != PW);
    accept  = lat_fall & is_cand & ~lane_bad_nxt & ~bad_len;
  end

  // Bus sampling and segment accumulation; a latch fall closes and clears the segment.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      pix_q        <= 1'b0;
      lat_q        <= 1'b0;
      armed        <= 1'b0;
      shreg        <= '0;
      seg_cnt      <= '0;
      lat_cnt      <= '0;
      seg_lane_bad <= 1'b0;
    end else begin
      pix_q <= pixclock_in;
      lat_q <= latch_in;
      armed <= 1'b1;
      shreg <= shreg_nxt;
      if (lat_fall) begin
        seg_cnt      <= '0;
        lat_cnt      <= '0;
        seg_lane_bad <= 1'b0;
      end else begin
        seg_cnt      <= seg_cnt_nxt;
        lat_cnt      <= lat_cnt_nxt;
        seg_lane_bad <= lane_bad_nxt;
      end
    end
  end

  // Decode outputs: strobes for one cycle after the fall, registers and valid bits on accept.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      reg12_q           <= '0;
      reg13_q           <= '0;
      reg12_valid       <= 1'b0;
      reg13_valid       <= 1'b0;
      write_strobe      <= 1'b0;
      write_sel         <= 1'b0;
      data_latch_strobe <= 1'b0;
      latch_clocks      <= '0;
      cmd_err           <= 1'b0;
      lane_err          <= 1'b0;
      len_err           <= 1'b0;
    end else begin
      write_strobe      <= accept;
      write_sel         <= accept & is_r13;
      data_latch_strobe <= lat_fall & is_data;
      cmd_err           <= lat_fall & ~is_data & ~is_cand;
      lane_err          <= lat_fall & is_cand & lane_bad_nxt;
      len_err           <= lat_fall & is_cand & bad_len;
      if (lat_fall) latch_clocks <= cnt_sat;
      if (accept && is_r12) begin
        reg12_q     <= shreg_nxt;
        reg12_valid <= 1'b1;
      end
      if (accept && is_r13) begin
        reg13_q     <= shreg_nxt;
        reg13_valid <= 1'b1;
      end
    end
  end

  // Init is complete once both configuration registers have been written.
  always_comb begin
    init_done = reg12_valid & reg13_valid;
  end

endmodule

// File: tb/tb_fm6126_config_rx.sv
// Directed bench for fm6126_config_rx: register writes, data latch, error pulses, mid-frame reset.
module tb_fm6126_config_rx;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  rgb1_in = '0;
  logic [2:0]  rgb2_in = '0;
  logic        latch_in = 1'b0;
  logic        pixclock_in = 1'b0;
  logic [15:0] reg12_q, reg13_q;
  logic        reg12_valid, reg13_valid, init_done;
  logic        write_strobe, write_sel, data_latch_strobe;
  logic [4:0]  latch_clocks;
  logic        cmd_err, lane_err, len_err;
  logic [45:0] all_outs;

  int n_chk = 0;
  int n_err = 0;
  int n_ws = 0, n_dls = 0, n_cmd = 0, n_lane = 0, n_len = 0;

  fm6126_config_rx #(.PANEL_WIDTH(64)) dut (
    .clk_in(clk_in), .reset(reset), .rgb1_in(rgb1_in), .rgb2_in(rgb2_in),
    .latch_in(latch_in), .pixclock_in(pixclock_in),
    .reg12_q(reg12_q), .reg13_q(reg13_q), .reg12_valid(reg12_valid), .reg13_valid(reg13_valid),
    .init_done(init_done), .write_strobe(write_strobe), .write_sel(write_sel),
    .data_latch_strobe(data_latch_strobe), .latch_clocks(latch_clocks),
    .cmd_err(cmd_err), .lane_err(lane_err), .len_err(len_err)
  );

  always #5 clk_in = ~clk_in;

  assign all_outs = {reg12_q, reg13_q, reg12_valid, reg13_valid, init_done, write_strobe,
                     write_sel, data_latch_strobe, latch_clocks, cmd_err, lane_err, len_err};

  // Pulse counters sampled mid-cycle, between the posedge and the checking negedge.
  always @(posedge clk_in) begin
    #2;
    if (write_strobe)      n_ws++;
    if (data_latch_strobe) n_dls++;
    if (cmd_err)           n_cmd++;
    if (lane_err)          n_lane++;
    if (len_err)           n_len++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_counts();
    n_ws = 0; n_dls = 0; n_cmd = 0; n_lane = 0; n_len = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_in);
  endtask

  // Drive n pixclock edges (period 2) carrying val LSB-first per 16; latch high for the final
  // n_lat edges with its fall coinciding with the last edge; rgb2_in[1] inverted on edge bad.
  task automatic send_frame(input logic [15:0] val, input int n, input int n_lat, input int bad);
    logic       b;
    logic [2:0] l2;
    for (int i = 0; i < n; i++) begin
      b = val[i % 16];
      @(negedge clk_in);
      pixclock_in = 1'b0;
      rgb1_in     = {3{b}};
      l2          = {3{b}};
      if (i == bad) l2[1] = ~l2[1];
      rgb2_in     = l2;
      latch_in    = (i >= n - n_lat);
      @(negedge clk_in);
      pixclock_in = 1'b1;
      if (i == n - 1 && n_lat > 0) latch_in = 1'b0;
    end
  endtask

  // Return the bus to idle after a frame and let any stray pulses show up in the counters.
  task automatic end_frame();
    pixclock_in = 1'b0;
    rgb1_in = '0;
    rgb2_in = '0;
    idle(3);
  endtask

  initial begin
    // Reset state
    idle(3);
    check("reset outs", all_outs, 46'd0);
    reset = 1'b0;
    idle(3);
    check("post reset outs", all_outs, 46'd0);

    // REG12 write 0x7FFF, 12 latched edges
    clear_counts();
    send_frame(16'h7FFF, 64, 12, -1);
    @(negedge clk_in);
    check("r12 strobe", write_strobe, 1);
    check("r12 sel", write_sel, 0);
    check("r12 value", reg12_q, 16'h7FFF);
    check("r12 latch_clocks", latch_clocks, 12);
    check("r12 valid", reg12_valid, 1);
    check("r12 init_done", init_done, 0);
    pixclock_in = 1'b0;
    @(negedge clk_in);
    check("r12 strobe width", write_strobe, 0);
    end_frame();
    check("r12 one write", n_ws, 1);
    check("r12 no err", n_cmd + n_lane + n_len + n_dls, 0);

    // REG13 write 0x0040, 13 latched edges
    clear_counts();
    send_frame(16'h0040, 64, 13, -1);
    @(negedge clk_in);
    check("r13 strobe", write_strobe, 1);
    check("r13 sel", write_sel, 1);
    check("r13 value", reg13_q, 16'h0040);
    check("r13 latch_clocks", latch_clocks, 13);
    pixclock_in = 1'b0;
    @(negedge clk_in);
    check("r13 init_done", init_done, 1);
    check("r13 strobe width", write_strobe, 0);
    end_frame();
    check("r13 one write", n_ws, 1);
    check("r12 kept", reg12_q, 16'h7FFF);

    // Data latch: 3 latched edges
    clear_counts();
    send_frame(16'h1234, 64, 3, -1);
    @(negedge clk_in);
    check("data strobe", data_latch_strobe, 1);
    check("data latch_clocks", latch_clocks, 3);
    end_frame();
    check("data one strobe", n_dls, 1);
    check("data no write", n_ws, 0);
    check("data r12 kept", reg12_q, 16'h7FFF);
    check("data r13 kept", reg13_q, 16'h0040);

    // Lane error on edge 50 of a REG12 frame
    clear_counts();
    send_frame(16'h1111, 64, 12, 50);
    @(negedge clk_in);
    check("lane err", lane_err, 1);
    check("lane len_err", len_err, 0);
    end_frame();
    check("lane no write", n_ws, 0);
    check("lane r12 kept", reg12_q, 16'h7FFF);

    // Length error: 48-edge REG12 frame
    clear_counts();
    send_frame(16'h00AA, 48, 12, -1);
    @(negedge clk_in);
    check("len err", len_err, 1);
    check("len lane_err", lane_err, 0);
    end_frame();
    check("len no write", n_ws, 0);
    check("len r12 kept", reg12_q, 16'h7FFF);

    // Command error: 7 latched edges
    clear_counts();
    send_frame(16'h5555, 64, 7, -1);
    @(negedge clk_in);
    check("cmd err", cmd_err, 1);
    check("cmd latch_clocks", latch_clocks, 7);
    end_frame();
    check("cmd one pulse", n_cmd, 1);
    check("cmd no write", n_ws, 0);

    // Latch pulse with no edges
    clear_counts();
    latch_in = 1'b1;
    idle(2);
    latch_in = 1'b0;
    @(negedge clk_in);
    check("empty cmd err", cmd_err, 1);
    check("empty latch_clocks", latch_clocks, 0);
    idle(2);

    // Overwrite REG12
    clear_counts();
    send_frame(16'h0123, 64, 12, -1);
    @(negedge clk_in);
    check("ovw value", reg12_q, 16'h0123);
    end_frame();
    check("ovw valid", reg12_valid, 1);

    // Reset at edge 30 of a REG13 frame, pixclock left high
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      pixclock_in = 1'b0;
      rgb1_in = '1;
      rgb2_in = '1;
      @(negedge clk_in);
      pixclock_in = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk_in);
    check("mid reset outs", all_outs, 46'd0);
    @(negedge clk_in);
    reset = 1'b0;
    idle(3);
    check("after reset outs", all_outs, 46'd0);
    clear_counts();
    send_frame(16'h0040, 64, 13, -1);
    @(negedge clk_in);
    check("rst r13 value", reg13_q, 16'h0040);
    check("rst r13 sel", write_sel, 1);
    end_frame();
    check("rst one write", n_ws, 1);
    check("rst no err", n_cmd + n_lane + n_len + n_dls, 0);
    check("rst r12 cleared", reg12_q, 16'h0000);
    check("rst init_done", init_done, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
